// File: rtl/robot_packet_rx_pkg.sv
// Shared definitions for the robot position-packet receiver: packet field
// positions, grid bounds, FSM state encoding and the packet validity rule.
package robot_packet_rx_pkg;

    localparam int ROW_LSB   = 0;
    localparam int COL_LSB   = 2;
    localparam int DONE_BIT  = 5;
    localparam int PAR_BIT   = 7;

    localparam int GRID_ROWS = 4;
    localparam int GRID_COLS = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_ACK    = 2'd3
    } rx_state_t;

    // Odd parity across the whole byte (PAR_BIT included) and column on the grid.
    function automatic logic pkt_valid(input logic [7:0] pkt);
        logic [2:0] col;
        col = pkt[COL_LSB +: 3];
        return (^pkt) && (int'(col) <= GRID_COLS - 1);
    endfunction

endpackage

// File: rtl/robot_packet_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all zeros.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/robot_packet_rx.sv
// Receives position packets over a strobe/ack GPIO handshake, waits for the
// bus to settle, validates parity and range, and emits accepted grid positions.
//
// state  | meaning
// IDLE   | waiting for synchronised strobe; ACK_OUT low
// SETTLE | counting consecutive cycles of unchanged data
// CHECK  | one cycle: validate captured packet, update outputs
// ACK    | ACK_OUT high until strobe releases; timeout counter runs
module robot_packet_rx
    import robot_packet_rx_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [7:0] DATA_IN,
    input  logic       STROBE_IN,
    output logic       ACK_OUT,
    output logic       POS_VALID,
    output logic [1:0] POS_ROW,
    output logic [2:0] POS_COL,
    output logic       DONE,
    output logic [7:0] ERR_COUNT,
    output logic       TIMEOUT_FLAG
);

    localparam int              CW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [24:0]     TO_LAST     = 25'(TIMEOUT_CYCLES - 1);

    logic [8:0]    sync_q;
    logic          strb_s;
    logic [7:0]    data_s;
    rx_state_t     state;
    logic [7:0]    cap;
    logic [CW-1:0] stable_cnt;
    logic [24:0]   tmo_cnt;

    sync_2ff #(.WIDTH(9)) u_sync (
        .clk_sys (CLOCK),
        .rst_b   (RESET_N),
        .d       ({STROBE_IN, DATA_IN}),
        .q       (sync_q)
    );

    assign strb_s = sync_q[8];
    assign data_s = sync_q[7:0];

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_IDLE;
            cap          <= '0;
            stable_cnt   <= '0;
            tmo_cnt      <= '0;
            ACK_OUT      <= 1'b0;
            POS_VALID    <= 1'b0;
            POS_ROW      <= '0;
            POS_COL      <= '0;
            DONE         <= 1'b0;
            ERR_COUNT    <= '0;
            TIMEOUT_FLAG <= 1'b0;
        end else begin
            POS_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ACK_OUT <= 1'b0;
                    if (strb_s) begin
                        cap        <= data_s;
                        stable_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // A strobe withdrawn before settling is silently abandoned.
                    if (!strb_s) begin
                        state <= ST_IDLE;
                    end else if (data_s != cap) begin
                        cap        <= data_s;
                        stable_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                        if (stable_cnt == SETTLE_LAST) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (pkt_valid(cap)) begin
                        POS_ROW   <= cap[ROW_LSB +: 2];
                        POS_COL   <= cap[COL_LSB +: 3];
                        POS_VALID <= 1'b1;
                        if (cap[DONE_BIT]) begin
                            DONE <= 1'b1;
                        end
                    end else if (ERR_COUNT != 8'hFF) begin
                        ERR_COUNT <= ERR_COUNT + 8'd1;
                    end
                    ACK_OUT <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= ST_ACK;
                end
                ST_ACK: begin
                    if (!strb_s) begin
                        ACK_OUT <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        if (tmo_cnt != '1) begin
                            tmo_cnt <= tmo_cnt + 25'd1;
                        end
                        if (tmo_cnt >= TO_LAST) begin
                            TIMEOUT_FLAG <= 1'b1;
                        end
                    end
                end
                default: begin
                    ACK_OUT <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_robot_packet_rx.sv
// Directed bench for robot_packet_rx: handshake latency, parity/range rejects,
// sticky flags, settle behaviour, timeout and asynchronous reset.
module tb_robot_packet_rx;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       STROBE_IN = 1'b0;
    logic       ACK_OUT;
    logic       POS_VALID;
    logic [1:0] POS_ROW;
    logic [2:0] POS_COL;
    logic       DONE;
    logic [7:0] ERR_COUNT;
    logic       TIMEOUT_FLAG;

    int n_checks = 0;
    int n_errors = 0;
    int pv_count = 0;
    int pv0;

    robot_packet_rx #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .DATA_IN      (DATA_IN),
        .STROBE_IN    (STROBE_IN),
        .ACK_OUT      (ACK_OUT),
        .POS_VALID    (POS_VALID),
        .POS_ROW      (POS_ROW),
        .POS_COL      (POS_COL),
        .DONE         (DONE),
        .ERR_COUNT    (ERR_COUNT),
        .TIMEOUT_FLAG (TIMEOUT_FLAG)
    );

    always #20 CLOCK = ~CLOCK;

    always @(posedge CLOCK) begin
        if (POS_VALID === 1'b1) pv_count <= pv_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl, input int maxc, input string tag);
        int n = 0;
        while (ACK_OUT !== lvl && n < maxc) begin
            @(negedge CLOCK);
            n++;
        end
        chk(tag, 32'(ACK_OUT === lvl), 32'd1);
    endtask

    task automatic send_pkt(input logic [7:0] d);
        @(negedge CLOCK);
        DATA_IN   = d;
        STROBE_IN = 1'b1;
        wait_ack(1'b1, 40, "ack_rise");
        STROBE_IN = 1'b0;
        wait_ack(1'b0, 20, "ack_fall");
        repeat (2) @(negedge CLOCK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},  32'(ACK_OUT), 0);
        chk({tag, "_pv"},   32'(POS_VALID), 0);
        chk({tag, "_row"},  32'(POS_ROW), 0);
        chk({tag, "_col"},  32'(POS_COL), 0);
        chk({tag, "_done"}, 32'(DONE), 0);
        chk({tag, "_err"},  32'(ERR_COUNT), 0);
        chk({tag, "_tmo"},  32'(TIMEOUT_FLAG), 0);
    endtask

    initial begin
        // reset state
        #5;
        chk_all_zero("reset");
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK);

        // valid packet 0x85: row1 col1, exact latency
        DATA_IN   = 8'h85;
        STROBE_IN = 1'b1;
        repeat (7) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("pv_before_e7", 32'(POS_VALID), 0);
        chk("ack_before_e7", 32'(ACK_OUT), 0);
        @(negedge CLOCK);
        chk("pv_e7", 32'(POS_VALID), 1);
        chk("ack_e7", 32'(ACK_OUT), 1);
        chk("row_85", 32'(POS_ROW), 1);
        chk("col_85", 32'(POS_COL), 1);
        @(negedge CLOCK);
        chk("pv_one_cycle", 32'(POS_VALID), 0);
        chk("ack_held", 32'(ACK_OUT), 1);
        DATA_IN   = 8'h00;
        STROBE_IN = 1'b0;
        @(negedge CLOCK);
        chk("ack_drop_d0", 32'(ACK_OUT), 1);
        @(negedge CLOCK);
        chk("ack_drop_d1", 32'(ACK_OUT), 1);
        @(negedge CLOCK);
        chk("ack_drop_d2", 32'(ACK_OUT), 0);
        chk("row_after_ack_data", 32'(POS_ROW), 1);
        chk("err_after_85", 32'(ERR_COUNT), 0);
        repeat (2) @(negedge CLOCK);

        // parity error 0x05
        pv0 = pv_count;
        DATA_IN   = 8'h05;
        STROBE_IN = 1'b1;
        wait_ack(1'b1, 40, "ack_rise_par");
        chk("ack_par", 32'(ACK_OUT), 1);
        @(negedge CLOCK);
        chk("err_par", 32'(ERR_COUNT), 1);
        STROBE_IN = 1'b0;
        wait_ack(1'b0, 20, "ack_fall_par");
        chk("pv_par", 32'(pv_count), 32'(pv0));
        chk("row_par_hold", 32'(POS_ROW), 1);

        // range error: col5 with odd parity
        send_pkt(8'h94);
        chk("err_range", 32'(ERR_COUNT), 2);
        chk("pv_range", 32'(pv_count), 32'(pv0));
        chk("col_range_hold", 32'(POS_COL), 1);

        // 0x33 has even parity -> rejected
        send_pkt(8'h33);
        chk("err_33", 32'(ERR_COUNT), 3);
        chk("done_33", 32'(DONE), 0);

        // 0xB3: row3 col4 done, odd parity
        send_pkt(8'hB3);
        chk("pv_b3", 32'(pv_count), 32'(pv0 + 1));
        chk("row_b3", 32'(POS_ROW), 3);
        chk("col_b3", 32'(POS_COL), 4);
        chk("done_b3", 32'(DONE), 1);
        chk("err_b3", 32'(ERR_COUNT), 3);

        send_pkt(8'h85);
        chk("done_sticky", 32'(DONE), 1);
        chk("row_85b", 32'(POS_ROW), 1);

        // glitchy data while strobe held
        pv0 = pv_count;
        @(negedge CLOCK);
        STROBE_IN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            DATA_IN = i[0] ? 8'h05 : 8'h84;
            repeat (2) @(negedge CLOCK);
        end
        DATA_IN = 8'h85;
        wait_ack(1'b1, 40, "ack_rise_glitch");
        STROBE_IN = 1'b0;
        wait_ack(1'b0, 20, "ack_fall_glitch");
        repeat (2) @(negedge CLOCK);
        chk("pv_glitch", 32'(pv_count), 32'(pv0 + 1));
        chk("err_glitch", 32'(ERR_COUNT), 3);

        // strobe pulse shorter than settle window
        DATA_IN   = 8'hB3;
        STROBE_IN = 1'b1;
        repeat (3) @(negedge CLOCK);
        STROBE_IN = 1'b0;
        repeat (12) @(negedge CLOCK);
        chk("pv_short", 32'(pv_count), 32'(pv0 + 1));
        chk("err_short", 32'(ERR_COUNT), 3);
        chk("ack_short", 32'(ACK_OUT), 0);
        chk("col_short", 32'(POS_COL), 1);

        // stuck strobe: flag after exactly 16 ACK cycles
        DATA_IN   = 8'h85;
        STROBE_IN = 1'b1;
        repeat (8) @(negedge CLOCK);
        chk("ack_tmo_start", 32'(ACK_OUT), 1);
        repeat (15) @(negedge CLOCK);
        chk("tmo_at_15", 32'(TIMEOUT_FLAG), 0);
        @(negedge CLOCK);
        chk("tmo_at_16", 32'(TIMEOUT_FLAG), 1);
        STROBE_IN = 1'b0;
        wait_ack(1'b0, 20, "ack_fall_tmo");
        repeat (3) @(negedge CLOCK);
        chk("tmo_sticky", 32'(TIMEOUT_FLAG), 1);

        // reset mid-ACK
        DATA_IN   = 8'h85;
        STROBE_IN = 1'b1;
        wait_ack(1'b1, 40, "ack_rise_rst");
        #5 RESET_N = 1'b0;
        #1;
        chk_all_zero("rst_ack");
        STROBE_IN = 1'b0;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK);

        // error counter saturation
        for (int i = 0; i < 255; i++) send_pkt(8'h05);
        chk("err_255", 32'(ERR_COUNT), 255);
        send_pkt(8'h05);
        chk("err_sat", 32'(ERR_COUNT), 255);

        // reset mid-SETTLE, then a fresh packet
        send_pkt(8'hB3);
        chk("done_pre_rst", 32'(DONE), 1);
        DATA_IN   = 8'h85;
        STROBE_IN = 1'b1;
        repeat (4) @(negedge CLOCK);
        #5 RESET_N = 1'b0;
        #1;
        chk_all_zero("rst_settle");
        STROBE_IN = 1'b0;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK);
        pv0 = pv_count;
        send_pkt(8'h85);
        chk("pv_fresh", 32'(pv_count), 32'(pv0 + 1));
        chk("row_fresh", 32'(POS_ROW), 1);
        chk("col_fresh", 32'(POS_COL), 1);
        chk("done_fresh", 32'(DONE), 0);
        chk("err_fresh", 32'(ERR_COUNT), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
